// File: rtl/spi_sram_model.sv
`timescale 1ns/1ps
// spi_sram_model
//   Clock-oversampled SPI serial-SRAM emulator with a 23LC1024-style command set
//   (READ 0x03, WRITE 0x02, RDMR 0x05, WRMR 0x01). SPI mode 0 (CPOL=0/CPHA=0).
//   A mode register selects byte / page / sequential address advance.
//   The master's sclk half period must be at least 4 clk periods.
// Ports
//   clk     in   system clock, all logic on its rising edge
//   reset   in   asynchronous active-low reset (memory content is kept)
//   sclk    in   SPI clock from master, asynchronous to clk
//   ce      in   chip enable, active-low
//   si      in   serial data in, MSB first
//   so      out  serial data out, MSB first, never tri-stated
//   mode_o  out  mode register bits [7:6]
//   busy    out  high while ce is low and a transaction is in progress
module spi_sram_model #(
    parameter int    DEPTH_BYTES = 131072,
    parameter int    ADDR_BYTES  = 3,
    parameter int    PAGE_BYTES  = 32,
    parameter string INIT_FILE   = ""
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       ce,
    input  logic       si,
    output logic       so,
    output logic [1:0] mode_o,
    output logic       busy
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = $clog2(8 * ADDR_BYTES);
    localparam logic [CW-1:0] BIT7      = CW'(7);
    localparam logic [CW-1:0] ADDR_LAST = CW'(8 * ADDR_BYTES - 1);
    localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DATA_RD, DATA_WR, MODE_RD, MODE_WR, IGNORE
    } state_t;

    logic [7:0] mem [DEPTH_BYTES];

    // Power-up image; reset never touches the array.
    initial begin
        for (int i = 0; i < DEPTH_BYTES; i++) mem[i] = 8'h00;
    end

    // Two-stage synchronisers; sclk_p_q is the previous synchronised sclk for edge detect.
    logic sclk_m_q, sclk_s_q, sclk_p_q, ce_m_q, ce_s_q, si_m_q, si_s_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_m_q <= 1'b0; sclk_s_q <= 1'b0; sclk_p_q <= 1'b0;
            ce_m_q   <= 1'b1; ce_s_q   <= 1'b1;
            si_m_q   <= 1'b0; si_s_q   <= 1'b0;
        end else begin
            sclk_m_q <= sclk;   sclk_s_q <= sclk_m_q; sclk_p_q <= sclk_s_q;
            ce_m_q   <= ce;     ce_s_q   <= ce_m_q;
            si_m_q   <= si;     si_s_q   <= si_m_q;
        end
    end

    logic sclk_rise, sclk_fall;
    assign sclk_rise = sclk_s_q & ~sclk_p_q;
    assign sclk_fall = ~sclk_s_q & sclk_p_q;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    shreg_q, shreg_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    tx_q, tx_d;
    logic          so_q, so_d;
    logic [1:0]    mode_q, mode_d;
    logic          is_rd_q, is_rd_d;
    logic          done_q, done_d;   // first data byte of this transaction completed

    logic [7:0]    rx_byte;
    logic [AW-1:0] addr_in, addr_adv;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [1:0] m);
        logic [AW-1:0] inc;
        inc = a + AW'(1);
        case (m)
            2'b00:   next_addr = a;
            2'b10:   next_addr = (a & ~PAGE_MASK) | (inc & PAGE_MASK);
            default: next_addr = inc;   // 01 and reserved 11
        endcase
    endfunction

    assign rx_byte  = {shreg_q, si_s_q};
    assign addr_in  = {addr_q[AW-2:0], si_s_q};   // upper address bits fall off the top
    assign addr_adv = next_addr(addr_q, mode_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        so_d      = so_q;
        mode_d    = mode_q;
        is_rd_d   = is_rd_q;
        done_d    = done_q;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = rx_byte;
        if (ce_s_q) begin
            // Deselect discards any partial byte; completed writes already happened.
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
            so_d    = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
                CMD: if (sclk_rise) begin
                    shreg_d = rx_byte[6:0];
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == BIT7) begin
                        cnt_d = '0;
                        case (rx_byte)
                            8'h03: begin state_d = ADDR; is_rd_d = 1'b1; end
                            8'h02: begin state_d = ADDR; is_rd_d = 1'b0; end
                            8'h05: begin state_d = MODE_RD; tx_d = {mode_q, 6'b0}; end
                            8'h01: state_d = MODE_WR;
                            default: state_d = IGNORE;
                        endcase
                    end
                end
                ADDR: if (sclk_rise) begin
                    addr_d = addr_in;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d = '0;
                        if (is_rd_q) begin
                            state_d = DATA_RD;
                            tx_d    = mem[addr_in];
                        end else begin
                            state_d = DATA_WR;
                        end
                    end
                end
                DATA_RD: if (sclk_fall) begin
                    so_d  = (mode_q == 2'b00 && done_q) ? 1'b0 : tx_q[7];
                    tx_d  = {tx_q[6:0], 1'b0};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == BIT7) begin
                        // bit0 is on the wire: preload the next byte so there is no gap.
                        cnt_d  = '0;
                        done_d = 1'b1;
                        addr_d = addr_adv;
                        tx_d   = mem[addr_adv];
                    end
                end
                DATA_WR: if (sclk_rise) begin
                    shreg_d = rx_byte[6:0];
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == BIT7) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                        addr_d = addr_adv;
                        mem_we = !(mode_q == 2'b00 && done_q);
                    end
                end
                MODE_RD: if (sclk_fall) begin
                    so_d = tx_q[7];
                    tx_d = {tx_q[6:0], tx_q[7]};   // rotate so the byte repeats
                end
                MODE_WR: if (sclk_rise && !done_q) begin
                    shreg_d = rx_byte[6:0];
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == BIT7) begin
                        mode_d = rx_byte[7:6];
                        done_d = 1'b1;
                    end
                end
                default: so_d = 1'b0;   // IGNORE
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            addr_q  <= '0;
            tx_q    <= '0;
            so_q    <= 1'b0;
            mode_q  <= 2'b01;
            is_rd_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            addr_q  <= addr_d;
            tx_q    <= tx_d;
            so_q    <= so_d;
            mode_q  <= mode_d;
            is_rd_q <= is_rd_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign so     = so_q;
    assign mode_o = mode_q;
    assign busy   = ~ce_s_q & (state_q != IDLE);

endmodule

// File: tb/tb_spi_sram_model.sv
`timescale 1ns/1ps
module tb_spi_sram_model;
    localparam int DEPTH = 4096;
    localparam int PAGE  = 32;
    localparam int HALF  = 50;   // sclk half period: 5 clk periods

    logic clk = 1'b0;
    logic reset, sclk, ce, si;
    logic so, busy;
    logic [1:0] mode_o;

    spi_sram_model #(.DEPTH_BYTES(DEPTH), .ADDR_BYTES(3), .PAGE_BYTES(PAGE), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .ce(ce), .si(si),
        .so(so), .mode_o(mode_o), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [7:0] mem_m [0:DEPTH-1];
    int         mode_m;
    logic [7:0] exp_q [$];
    logic [7:0] wbuf [8];

    int n_checks = 0;
    int n_errors = 0;
    logic capture = 1'b0;
    logic [7:0] rx_sh = 8'h00;
    int rx_n = 0;

    function automatic int adv(input int a);
        case (mode_m)
            0:       return a;
            2:       return (a / PAGE) * PAGE + ((a + 1) % PAGE);
            default: return (a + 1) % DEPTH;
        endcase
    endfunction

    // Monitor: master-side sampling of so on each sclk rise during data phases.
    always @(posedge sclk) begin
        if (capture) begin
            rx_sh = {rx_sh[6:0], so};
            rx_n++;
            if (rx_n == 8) begin
                logic [7:0] e;
                rx_n = 0;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL so_byte: got %02h with nothing expected", rx_sh);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_sh !== e) begin
                        n_errors++;
                        $display("FAIL so_byte: got %02h expected %02h", rx_sh, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            si = tx[i];
            #HALF sclk = 1'b1;
            #HALF sclk = 1'b0;
        end
    endtask

    task automatic spi_begin();
        @(negedge clk);
        ce = 1'b0;
        #(2*HALF);
    endtask

    task automatic spi_end();
        #HALF ce = 1'b1;
        #(4*HALF);
    endtask

    task automatic send_addr(input int addr);
        spi_bits(addr[23:16], 8);
        spi_bits(addr[15:8], 8);
        spi_bits(addr[7:0], 8);
    endtask

    task automatic do_write(input int addr, input int n);
        int a;
        a = addr % DEPTH;
        for (int i = 0; i < n; i++) begin
            if (!(mode_m == 0 && i > 0)) mem_m[a] = wbuf[i];
            a = adv(a);
        end
        spi_begin();
        spi_bits(8'h02, 8);
        send_addr(addr);
        for (int i = 0; i < n; i++) spi_bits(wbuf[i], 8);
        spi_end();
    endtask

    task automatic do_read(input int addr, input int n);
        int a;
        a = addr % DEPTH;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back((mode_m == 0 && i > 0) ? 8'h00 : mem_m[a]);
            a = adv(a);
        end
        spi_begin();
        spi_bits(8'h03, 8);
        send_addr(addr);
        capture = 1'b1;
        for (int i = 0; i < n; i++) spi_bits(8'($urandom), 8);
        capture = 1'b0;
        spi_end();
    endtask

    task automatic do_wrmr(input logic [7:0] v);
        mode_m = int'(v[7:6]);
        spi_begin();
        spi_bits(8'h01, 8);
        spi_bits(v, 8);
        spi_end();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        mode_m = 1;
        reset = 1'b0; ce = 1'b1; sclk = 1'b0; si = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_so", {7'b0, so}, 8'h00);
        chk("reset_busy", {7'b0, busy}, 8'h00);
        chk("reset_mode", {6'b0, mode_o}, 8'h01);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // RDMR after reset
        spi_begin();
        spi_bits(8'h05, 8);
        chk("rdmr_busy", {7'b0, busy}, 8'h01);
        chk("rdmr_mode", {6'b0, mode_o}, 8'h01);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h40);
        capture = 1'b1;
        spi_bits(8'h00, 8);
        spi_bits(8'h00, 8);
        capture = 1'b0;
        #HALF ce = 1'b1;
        #30;
        chk("rdmr_busy_after", {7'b0, busy}, 8'h00);
        #(4*HALF);

        // Basic write/read
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        do_write(32'h10, 2);
        do_read(32'h10, 2);
        do_read(32'h11, 1);

        // Sequential wrap at the top of memory
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(DEPTH - 1, 2);
        do_read(DEPTH - 1, 2);
        do_read(0, 1);

        // Page mode, then byte mode
        do_wrmr(8'h80);
        chk("wrmr_page", {6'b0, mode_o}, 8'h02);
        wbuf[0] = 8'h01; wbuf[1] = 8'h02;
        do_write(32'h1F, 2);
        do_read(32'h1F, 2);
        do_read(32'h20, 1);
        do_wrmr(8'h00);
        chk("wrmr_byte", {6'b0, mode_o}, 8'h00);
        do_read(32'h1F, 2);
        wbuf[0] = 8'h77; wbuf[1] = 8'h88;
        do_write(32'h30, 2);
        do_read(32'h30, 1);
        do_wrmr(8'h40);
        do_read(32'h30, 2);

        // Abort mid-byte: only the completed byte lands
        mem_m[32'h40] = 8'hEE;
        spi_begin();
        spi_bits(8'h02, 8);
        send_addr(32'h40);
        spi_bits(8'hEE, 8);
        spi_bits(8'h5A, 5);
        #HALF ce = 1'b1;
        #30;
        chk("abort_busy", {7'b0, busy}, 8'h00);
        #(4*HALF);
        do_read(32'h40, 2);

        // Unknown command: so stays low, memory untouched
        spi_begin();
        spi_bits(8'hFF, 8);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        capture = 1'b1;
        spi_bits(8'hFF, 8);
        spi_bits(8'h02, 8);
        capture = 1'b0;
        spi_end();
        do_read(32'h10, 2);

        // Reset in the middle of a READ
        spi_begin();
        spi_bits(8'h03, 8);
        send_addr(32'h10);
        spi_bits(8'h00, 4);
        @(negedge clk);
        reset = 1'b0;
        ce = 1'b1;
        #1;
        chk("midrst_so", {7'b0, so}, 8'h00);
        chk("midrst_busy", {7'b0, busy}, 8'h00);
        chk("midrst_mode", {6'b0, mode_o}, 8'h01);
        mode_m = 1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        do_read(32'h10, 2);
        do_read(DEPTH - 1, 2);

        // Randomised traffic across all modes
        for (int it = 0; it < 20; it++) begin
            int n, a;
            do_wrmr(8'($urandom_range(0, 3) << 6));
            n = $urandom_range(1, 4);
            a = $urandom_range(0, 24'hFFFFFF);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            do_write(a, n);
            if ($urandom_range(0, 1) == 1) a = $urandom_range(0, 24'hFFFFFF);
            do_read(a, $urandom_range(1, 4));
        end

        // Every expected byte must have been seen
        repeat (20) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d bytes left expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
